// File: rtl/eth_pkg.sv
// eth_pkg: shared XGMII constants, link-fault status codes and FSM state codes.
//   XGMII_SEQUENCE   - lane0 control character of a sequence ordered set
//   XGMII_LF_CODE    - lane3 value of a local-fault sequence
//   XGMII_RF_CODE    - lane3 value of a remote-fault sequence
//   link_status_e    - 00 OK, 01 local fault, 10 remote fault
//   lf_state_e       - link-fault FSM states
//   sat_inc16()      - 16-bit increment that sticks at 16'hFFFF
package eth_pkg;

  localparam logic [7:0] XGMII_SEQUENCE = 8'h9C;
  localparam logic [7:0] XGMII_LF_CODE  = 8'h01;
  localparam logic [7:0] XGMII_RF_CODE  = 8'h02;

  typedef enum logic [1:0] {
    LINK_OK           = 2'b00,
    LINK_LOCAL_FAULT  = 2'b01,
    LINK_REMOTE_FAULT = 2'b10
  } link_status_e;

  typedef enum logic [1:0] {
    ST_INIT  = 2'b00,
    ST_COUNT = 2'b01,
    ST_FAULT = 2'b10
  } lf_state_e;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/xgmii_seq_decode.sv
// xgmii_seq_decode: combinational detector for link-fault sequence columns.
//   xgmii_data_i - one XGMII column, lane0 = [7:0]
//   xgmii_ctl_i  - control bits, bit n qualifies lane n
//   seq_valid    - column is a local- or remote-fault sequence
//   seq_type     - LINK_LOCAL_FAULT / LINK_REMOTE_FAULT, LINK_OK when not valid
// Reserved sequence payloads (any other lane1..lane3 content) are ignored.
module xgmii_seq_decode
  import eth_pkg::*;
#(
  parameter int XGMII_DATA_WIDTH = 32
) (
  input  logic [XGMII_DATA_WIDTH-1:0]   xgmii_data_i,
  input  logic [XGMII_DATA_WIDTH/8-1:0] xgmii_ctl_i,
  output logic                          seq_valid,
  output link_status_e                  seq_type
);

  localparam int CTL_W = XGMII_DATA_WIDTH / 8;

  logic hdr_ok;
  logic is_lf;
  logic is_rf;

  assign hdr_ok = (xgmii_ctl_i == CTL_W'(1)) &&
                  (xgmii_data_i[7:0]   == XGMII_SEQUENCE) &&
                  (xgmii_data_i[15:8]  == 8'h00) &&
                  (xgmii_data_i[23:16] == 8'h00);
  assign is_lf  = hdr_ok && (xgmii_data_i[31:24] == XGMII_LF_CODE);
  assign is_rf  = hdr_ok && (xgmii_data_i[31:24] == XGMII_RF_CODE);

  assign seq_valid = is_lf || is_rf;

  always_comb begin
    seq_type = LINK_OK;
    if (is_lf) begin
      seq_type = LINK_LOCAL_FAULT;
    end else if (is_rf) begin
      seq_type = LINK_REMOTE_FAULT;
    end
  end

endmodule

// File: rtl/rx_link_fault_ctrl.sv
// rx_link_fault_ctrl: RX link-fault state machine for a 32-bit XGMII interface.
//   rx_clk, rx_rst         - clock, synchronous active-high reset
//   in_xgmii_data/_ctl     - received XGMII column
//   stats_clear            - pulse clearing both fault counters
//   link_fault_status      - 00 OK, 01 local fault, 10 remote fault
//   mac_rx_enable          - high while status is OK
//   tx_send_remote_fault   - high while status is local fault
//   tx_send_idle           - high while status is remote fault
//   local/remote_fault_count - saturating counts of entries into each fault status
//   dbg_state, dbg_seq_cnt - current FSM state and sequence counter
// A fault is declared after SEQ_CNT_LIMIT same-type sequences with fewer than
// COL_CNT_LIMIT non-fault columns between them; COL_CNT_LIMIT consecutive
// non-fault columns clear it. All outputs are registered (latency 1).
module rx_link_fault_ctrl
  import eth_pkg::*;
#(
  parameter int XGMII_DATA_WIDTH = 32,
  parameter int COL_CNT_LIMIT    = 128,
  parameter int SEQ_CNT_LIMIT    = 4
) (
  input  logic                                 rx_clk,
  input  logic                                 rx_rst,
  input  logic [XGMII_DATA_WIDTH-1:0]          in_xgmii_data,
  input  logic [XGMII_DATA_WIDTH/8-1:0]        in_xgmii_ctl,
  input  logic                                 stats_clear,
  output logic [1:0]                           link_fault_status,
  output logic                                 mac_rx_enable,
  output logic                                 tx_send_remote_fault,
  output logic                                 tx_send_idle,
  output logic [15:0]                          local_fault_count,
  output logic [15:0]                          remote_fault_count,
  output logic [1:0]                           dbg_state,
  output logic [$clog2(SEQ_CNT_LIMIT+1)-1:0]   dbg_seq_cnt
);

  localparam int COL_W = $clog2(COL_CNT_LIMIT);
  localparam int SEQ_W = $clog2(SEQ_CNT_LIMIT + 1);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(COL_CNT_LIMIT - 1);
  localparam logic [SEQ_W-1:0] SEQ_LAST = SEQ_W'(SEQ_CNT_LIMIT);

  logic         seq_valid;
  link_status_e seq_type;

  lf_state_e          state_q,  state_d;
  logic [COL_W-1:0]   col_cnt_q, col_cnt_d;
  logic [SEQ_W-1:0]   seq_cnt_q, seq_cnt_d;
  link_status_e       last_type_q, last_type_d;
  link_status_e       status_q, status_d;
  logic               mac_en_q, tx_rf_q, tx_idle_q;
  logic [15:0]        local_cnt_q, local_cnt_d;
  logic [15:0]        remote_cnt_q, remote_cnt_d;
  logic               quiet_done;

  xgmii_seq_decode #(
    .XGMII_DATA_WIDTH(XGMII_DATA_WIDTH)
  ) u_decode (
    .xgmii_data_i(in_xgmii_data),
    .xgmii_ctl_i (in_xgmii_ctl),
    .seq_valid   (seq_valid),
    .seq_type    (seq_type)
  );

  // The current non-fault column is the COL_CNT_LIMIT-th in a row.
  assign quiet_done = (col_cnt_q == COL_LAST);

  always_comb begin
    state_d     = state_q;
    col_cnt_d   = col_cnt_q;
    seq_cnt_d   = seq_cnt_q;
    last_type_d = last_type_q;
    status_d    = status_q;
    unique case (state_q)
      ST_INIT: begin
        if (seq_valid) begin
          last_type_d = seq_type;
          seq_cnt_d   = SEQ_W'(1);
          col_cnt_d   = '0;
          state_d     = ST_COUNT;
        end
      end
      ST_COUNT, ST_FAULT: begin
        if (seq_valid) begin
          col_cnt_d = '0;
          if (seq_type != last_type_q) begin
            // A new type restarts qualification; the old status is held.
            last_type_d = seq_type;
            seq_cnt_d   = SEQ_W'(1);
            state_d     = ST_COUNT;
          end else if (state_q == ST_COUNT) begin
            seq_cnt_d = seq_cnt_q + SEQ_W'(1);
            if (seq_cnt_d == SEQ_LAST) begin
              state_d  = ST_FAULT;
              status_d = last_type_q;
            end
          end
        end else if (quiet_done) begin
          state_d   = ST_INIT;
          status_d  = LINK_OK;
          seq_cnt_d = '0;
          col_cnt_d = '0;
        end else begin
          col_cnt_d = col_cnt_q + COL_W'(1);
        end
      end
      default: begin
        state_d = ST_INIT;
      end
    endcase
  end

  // Counters step on status entry edges; a coinciding clear wins.
  always_comb begin
    local_cnt_d  = local_cnt_q;
    remote_cnt_d = remote_cnt_q;
    if (status_d == LINK_LOCAL_FAULT && status_q != LINK_LOCAL_FAULT) begin
      local_cnt_d = sat_inc16(local_cnt_q);
    end
    if (status_d == LINK_REMOTE_FAULT && status_q != LINK_REMOTE_FAULT) begin
      remote_cnt_d = sat_inc16(remote_cnt_q);
    end
    if (stats_clear) begin
      local_cnt_d  = '0;
      remote_cnt_d = '0;
    end
  end

  always_ff @(posedge rx_clk) begin
    if (rx_rst) begin
      state_q      <= ST_INIT;
      col_cnt_q    <= '0;
      seq_cnt_q    <= '0;
      last_type_q  <= LINK_OK;
      status_q     <= LINK_OK;
      mac_en_q     <= 1'b1;
      tx_rf_q      <= 1'b0;
      tx_idle_q    <= 1'b0;
      local_cnt_q  <= '0;
      remote_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      col_cnt_q    <= col_cnt_d;
      seq_cnt_q    <= seq_cnt_d;
      last_type_q  <= last_type_d;
      status_q     <= status_d;
      mac_en_q     <= (status_d == LINK_OK);
      tx_rf_q      <= (status_d == LINK_LOCAL_FAULT);
      tx_idle_q    <= (status_d == LINK_REMOTE_FAULT);
      local_cnt_q  <= local_cnt_d;
      remote_cnt_q <= remote_cnt_d;
    end
  end

  assign link_fault_status    = status_q;
  assign mac_rx_enable        = mac_en_q;
  assign tx_send_remote_fault = tx_rf_q;
  assign tx_send_idle         = tx_idle_q;
  assign local_fault_count    = local_cnt_q;
  assign remote_fault_count   = remote_cnt_q;
  assign dbg_state            = state_q;
  assign dbg_seq_cnt          = seq_cnt_q;

endmodule

// File: tb/tb_rx_link_fault_ctrl.sv
module tb_rx_link_fault_ctrl;
  import eth_pkg::*;

  localparam int COL_LIM = 128;
  localparam int SEQ_LIM = 4;
  localparam logic [31:0] LF_COL  = 32'h0100_009C;
  localparam logic [31:0] RF_COL  = 32'h0200_009C;
  localparam logic [31:0] IDL_COL = 32'h0707_0707;

  // ---------------- clock / reset ----------------
  logic        rx_clk = 1'b0;
  logic        rx_rst = 1'b0;
  logic [31:0] in_xgmii_data = IDL_COL;
  logic [3:0]  in_xgmii_ctl = 4'hF;
  logic        stats_clear = 1'b0;
  logic [1:0]  link_fault_status;
  logic        mac_rx_enable, tx_send_remote_fault, tx_send_idle;
  logic [15:0] local_fault_count, remote_fault_count;
  logic [1:0]  dbg_state;
  logic [2:0]  dbg_seq_cnt;

  always #5 rx_clk = ~rx_clk;

  rx_link_fault_ctrl #(
    .XGMII_DATA_WIDTH(32), .COL_CNT_LIMIT(COL_LIM), .SEQ_CNT_LIMIT(SEQ_LIM)
  ) dut (
    .rx_clk(rx_clk), .rx_rst(rx_rst),
    .in_xgmii_data(in_xgmii_data), .in_xgmii_ctl(in_xgmii_ctl),
    .stats_clear(stats_clear),
    .link_fault_status(link_fault_status), .mac_rx_enable(mac_rx_enable),
    .tx_send_remote_fault(tx_send_remote_fault), .tx_send_idle(tx_send_idle),
    .local_fault_count(local_fault_count), .remote_fault_count(remote_fault_count),
    .dbg_state(dbg_state), .dbg_seq_cnt(dbg_seq_cnt)
  );

  int checks = 0;
  int errors = 0;

  // ---------------- reference model ----------------
  // Tracks the current run of same-type sequences and the quiet gap since the
  // last sequence; status flips when the run is long enough or the gap expires.
  int m_status, m_type, m_run, m_quiet, m_lcnt, m_rcnt;

  function automatic int col_kind(input logic [31:0] d, input logic [3:0] c);
    if (c != 4'b0001 || d[7:0] != 8'h9C || d[15:8] != 8'h00 || d[23:16] != 8'h00) return 0;
    if (d[31:24] == 8'h01) return 1;
    if (d[31:24] == 8'h02) return 2;
    return 0;
  endfunction

  task automatic model_reset();
    m_status = 0; m_type = 0; m_run = 0; m_quiet = 0; m_lcnt = 0; m_rcnt = 0;
  endtask

  task automatic model_col(input int kind, input logic clr);
    int old_status;
    old_status = m_status;
    if (kind != 0) begin
      m_quiet = 0;
      if (m_run > 0 && kind == m_type) m_run++;
      else begin m_type = kind; m_run = 1; end
      if (m_run >= SEQ_LIM) m_status = kind;
    end else if (m_run > 0) begin
      m_quiet++;
      if (m_quiet == COL_LIM) begin m_status = 0; m_run = 0; m_quiet = 0; end
    end
    if (m_status != old_status && m_status == 1 && m_lcnt < 65535) m_lcnt++;
    if (m_status != old_status && m_status == 2 && m_rcnt < 65535) m_rcnt++;
    if (clr) begin m_lcnt = 0; m_rcnt = 0; end
  endtask

  function automatic logic [1:0] model_state();
    if (m_run == 0) return ST_INIT;
    if (m_run >= SEQ_LIM) return ST_FAULT;
    return ST_COUNT;
  endfunction

  // ---------------- checker / driver ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one column from a negedge, let the DUT sample it, return at the next negedge.
  task automatic step(input logic [31:0] d, input logic [3:0] c, input logic clr, input logic rst);
    in_xgmii_data = d;
    in_xgmii_ctl  = c;
    stats_clear   = clr;
    rx_rst        = rst;
    @(posedge rx_clk);
    if (rst) model_reset();
    else model_col(col_kind(d, c), clr);
    @(negedge rx_clk);
    stats_clear = 1'b0;
    rx_rst      = 1'b0;
  endtask

  task automatic steps(input logic [31:0] d, input logic [3:0] c, input int n);
    for (int i = 0; i < n; i++) step(d, c, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    step(IDL_COL, 4'hF, 1'b0, 1'b1);
  endtask

  // Random non-fault column, including near-miss sequence columns.
  task automatic rand_idle_col(output logic [31:0] d, output logic [3:0] c);
    case ($urandom_range(0, 4))
      0: begin d = IDL_COL; c = 4'hF; end
      1: begin d = $urandom; c = 4'h0; end
      2: begin d = {8'h03, 16'h0000, 8'h9C}; c = 4'h1; end
      3: begin d = {8'h01, 8'h00, 8'($urandom_range(1, 255)), 8'h9C}; c = 4'h1; end
      default: begin d = LF_COL; c = 4'($urandom_range(2, 15)); end
    endcase
  endtask

  // ---------------- scoreboard ----------------
  logic [35:0] exp_q[$];

  task automatic score_cycle();
    logic [35:0] e;
    exp_q.push_back({model_state(), 2'(m_status), 16'(m_lcnt), 16'(m_rcnt)});
    e = exp_q.pop_front();
    chk("rnd_state", 32'(dbg_state), 32'(e[35:34]));
    chk("rnd_status", 32'(link_fault_status), 32'(e[33:32]));
    chk("rnd_lcnt", 32'(local_fault_count), 32'(e[31:16]));
    chk("rnd_rcnt", 32'(remote_fault_count), 32'(e[15:0]));
    chk("rnd_enables", {29'd0, mac_rx_enable, tx_send_remote_fault, tx_send_idle},
        {29'd0, e[33:32] == 2'b00, e[33:32] == 2'b01, e[33:32] == 2'b10});
  endtask

  typedef struct {
    logic [31:0] d;
    logic [3:0]  c;
    logic [1:0]  exp_status;
  } vec_t;

  vec_t tbl[9];

  initial begin
    tbl[0] = '{32'h0100_009C, 4'h1, 2'b01};
    tbl[1] = '{32'h0200_009C, 4'h1, 2'b10};
    tbl[2] = '{32'h0300_009C, 4'h1, 2'b00};
    tbl[3] = '{32'h0100_019C, 4'h1, 2'b00};
    tbl[4] = '{32'h0101_009C, 4'h1, 2'b00};
    tbl[5] = '{32'h0100_009C, 4'h3, 2'b00};
    tbl[6] = '{32'h0100_009C, 4'h0, 2'b00};
    tbl[7] = '{32'h0100_00FB, 4'h1, 2'b00};
    tbl[8] = '{32'h0000_009C, 4'h1, 2'b00};

    model_reset();
    @(negedge rx_clk);

    // Reset values
    do_reset();
    chk("rst_status", 32'(link_fault_status), 32'd0);
    chk("rst_mac_en", 32'(mac_rx_enable), 32'd1);
    chk("rst_tx_rf", 32'(tx_send_remote_fault), 32'd0);
    chk("rst_tx_idle", 32'(tx_send_idle), 32'd0);
    chk("rst_lcnt", 32'(local_fault_count), 32'd0);
    chk("rst_rcnt", 32'(remote_fault_count), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'(ST_INIT));

    // Column classification table: four copies of each column
    for (int i = 0; i < 9; i++) begin
      do_reset();
      steps(tbl[i].d, tbl[i].c, 4);
      chk("tbl_status", 32'(link_fault_status), 32'(tbl[i].exp_status));
      chk("tbl_mac_en", 32'(mac_rx_enable), 32'(tbl[i].exp_status == 2'b00));
    end

    // Four local faults declare a local fault one cycle after the fourth
    do_reset();
    steps(LF_COL, 4'h1, 3);
    chk("lf3_status", 32'(link_fault_status), 32'd0);
    chk("lf3_seq", 32'(dbg_seq_cnt), 32'd3);
    step(LF_COL, 4'h1, 1'b0, 1'b0);
    chk("lf4_status", 32'(link_fault_status), 32'd1);
    chk("lf4_mac_en", 32'(mac_rx_enable), 32'd0);
    chk("lf4_tx_rf", 32'(tx_send_remote_fault), 32'd1);
    chk("lf4_lcnt", 32'(local_fault_count), 32'd1);

    // 127 quiet columns hold the fault, the 128th clears it
    steps(IDL_COL, 4'hF, 127);
    chk("q127_status", 32'(link_fault_status), 32'd1);
    step(IDL_COL, 4'hF, 1'b0, 1'b0);
    chk("q128_status", 32'(link_fault_status), 32'd0);
    chk("q128_mac_en", 32'(mac_rx_enable), 32'd1);
    chk("q128_state", 32'(dbg_state), 32'(ST_INIT));

    // A full quiet gap discards earlier sequences
    do_reset();
    steps(LF_COL, 4'h1, 3);
    steps(IDL_COL, 4'hF, 128);
    step(LF_COL, 4'h1, 1'b0, 1'b0);
    chk("gap128_status", 32'(link_fault_status), 32'd0);
    chk("gap128_state", 32'(dbg_state), 32'(ST_COUNT));
    chk("gap128_seq", 32'(dbg_seq_cnt), 32'd1);

    // One column short of the gap: the run continues and the fault is declared
    do_reset();
    steps(LF_COL, 4'h1, 3);
    steps(IDL_COL, 4'hF, 127);
    step(LF_COL, 4'h1, 1'b0, 1'b0);
    chk("gap127_status", 32'(link_fault_status), 32'd1);

    // Local to remote directly; remote counter preset to its ceiling
    do_reset();
    steps(LF_COL, 4'h1, 4);
    for (int i = 1; i <= 3; i++) begin
      step(RF_COL, 4'h1, 1'b0, 1'b0);
      chk("l2r_hold_status", 32'(link_fault_status), 32'd1);
    end
    force dut.remote_cnt_q = 16'hFFFF;
    m_rcnt = 65535;
    step(RF_COL, 4'h1, 1'b0, 1'b0);
    release dut.remote_cnt_q;
    chk("l2r_status", 32'(link_fault_status), 32'd2);
    chk("l2r_tx_idle", 32'(tx_send_idle), 32'd1);
    chk("l2r_tx_rf", 32'(tx_send_remote_fault), 32'd0);
    chk("sat_rcnt", 32'(remote_fault_count), 32'hFFFF);
    chk("l2r_lcnt", 32'(local_fault_count), 32'd1);

    // Clear coinciding with a local entry wins
    steps(LF_COL, 4'h1, 3);
    step(LF_COL, 4'h1, 1'b1, 1'b0);
    chk("clr_status", 32'(link_fault_status), 32'd1);
    chk("clr_lcnt", 32'(local_fault_count), 32'd0);
    chk("clr_rcnt", 32'(remote_fault_count), 32'd0);

    // Plain remote fault (counts from zero after the clear)
    steps(RF_COL, 4'h1, 4);
    chk("rf_status", 32'(link_fault_status), 32'd2);
    chk("rf_rcnt", 32'(remote_fault_count), 32'd1);

    // Reset mid-fault overrides a fault column on the same edge
    step(RF_COL, 4'h1, 1'b0, 1'b1);
    chk("midrst_status", 32'(link_fault_status), 32'd0);
    chk("midrst_mac_en", 32'(mac_rx_enable), 32'd1);
    chk("midrst_tx_idle", 32'(tx_send_idle), 32'd0);
    chk("midrst_tx_rf", 32'(tx_send_remote_fault), 32'd0);
    chk("midrst_rcnt", 32'(remote_fault_count), 32'd0);
    chk("midrst_lcnt", 32'(local_fault_count), 32'd0);
    chk("midrst_state", 32'(dbg_state), 32'(ST_INIT));
    chk("midrst_seq", 32'(dbg_seq_cnt), 32'd0);

    // Randomized bursts against the model
    for (int b = 0; b < 500; b++) begin
      int r, n;
      logic [31:0] d;
      logic [3:0] c;
      r = $urandom_range(0, 99);
      if (r < 35) begin
        n = $urandom_range(1, 6);
        for (int k = 0; k < n; k++) begin
          step(LF_COL, 4'h1, ($urandom_range(0, 49) == 0), 1'b0);
          score_cycle();
        end
      end else if (r < 70) begin
        n = $urandom_range(1, 6);
        for (int k = 0; k < n; k++) begin
          step(RF_COL, 4'h1, ($urandom_range(0, 49) == 0), 1'b0);
          score_cycle();
        end
      end else if (r < 97) begin
        n = $urandom_range(1, 140);
        for (int k = 0; k < n; k++) begin
          rand_idle_col(d, c);
          step(d, c, ($urandom_range(0, 49) == 0), 1'b0);
          score_cycle();
        end
      end else begin
        step(LF_COL, 4'h1, 1'b0, 1'b1);
        score_cycle();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
